gnn_layer_seq: RTL

- Time-multiplexed, parametrised graph-convolution layer engine.
- Node features stream in and are buffered. Each node's features are then aggregated over a runtime adjacency mask. Each aggregate is multiplied by a weight matrix using a single shared MAC, and the results stream out.
- Successor to the fixed 4-node, fully parallel layer datapath: node count, feature counts and widths are generalised, with valid/ready handshakes, backpressure and a runtime adjacency mask added.
- Instances chain layer-to-layer inside the accelerator.

---
 rtl/gnn_layer_seq_if.sv | 36 +++
 rtl/gnn_layer_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gnn_layer_seq_if.sv
// Stream/config bundle for gnn_layer_seq: feature input stream, adjacency and
// weight configuration, and the result output stream with status flags.
interface gnn_layer_seq_if #(
  parameter int NUM_NODES = 4,
  parameter int IN_FEAT   = 4,
  parameter int OUT_FEAT  = 2,
  parameter int DATA_W    = 5,
  parameter int W_W       = 5,
  parameter int ACC_W     = 21
);
  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int OW = (OUT_FEAT > 1) ? $clog2(OUT_FEAT) : 1;

  logic                              in_valid;
  logic                              in_ready;
  logic signed [DATA_W-1:0]          in_data;
  logic [NUM_NODES*NUM_NODES-1:0]    adj;
  logic [IN_FEAT*OUT_FEAT*W_W-1:0]   weights;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [ACC_W-1:0]           out_data;
  logic [NW-1:0]                     out_node;
  logic [OW-1:0]                     out_feat;
  logic                              busy;
  logic                              done;

  modport master (
    output in_valid, in_data, adj, weights, out_ready,
    input  in_ready, out_valid, out_data, out_node, out_feat, busy, done
  );

  modport slave (
    input  in_valid, in_data, adj, weights, out_ready,
    output in_ready, out_valid, out_data, out_node, out_feat, busy, done
  );
endinterface

// File: rtl/gnn_layer_seq.sv
// Time-multiplexed graph-convolution layer: buffer features, aggregate over adj,
// multiply by weights on one shared MAC. Optional ReLU via GNN_LAYER_RELU_EN.
module gnn_layer_seq #(
  parameter int NUM_NODES = 4,
  parameter int IN_FEAT   = 4,
  parameter int OUT_FEAT  = 2,
  parameter int DATA_W    = 5,
  parameter int W_W       = 5,
  parameter int ACC_W     = 21
) (
  input logic          clk,
  input logic          rst,
  gnn_layer_seq_if.slave bus
);
  localparam int AGG_W  = DATA_W + $clog2(NUM_NODES);
  localparam int PROD_W = AGG_W + W_W;
  localparam int NW     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int FW     = (IN_FEAT > 1) ? $clog2(IN_FEAT) : 1;
  localparam int OW     = (OUT_FEAT > 1) ? $clog2(OUT_FEAT) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NODES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(IN_FEAT - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT_FEAT - 1);

  typedef enum logic [1:0] {S_LOAD, S_AGGR, S_MAC, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [NW-1:0]           n_q, n_d, m_q, m_d;
  logic [FW-1:0]           f_q, f_d;
  logic [OW-1:0]           o_q, o_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, out_q, out_d;
  logic                    done_c, x_we, agg_we;

  logic signed [DATA_W-1:0] x_mem   [NUM_NODES][IN_FEAT];
  logic signed [AGG_W-1:0]  agg_mem [NUM_NODES][IN_FEAT];
  logic                     adj_arr [NUM_NODES][NUM_NODES];
  logic signed [W_W-1:0]    w_arr   [IN_FEAT][OUT_FEAT];

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term_ext, prod_ext, aggr_sum, mac_sum;

  function automatic logic signed [ACC_W-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
`ifdef GNN_LAYER_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  always_comb begin
    for (int n = 0; n < NUM_NODES; n++)
      for (int m = 0; m < NUM_NODES; m++)
        adj_arr[n][m] = bus.adj[n*NUM_NODES+m];
    for (int f = 0; f < IN_FEAT; f++)
      for (int o = 0; o < OUT_FEAT; o++)
        w_arr[f][o] = bus.weights[(f*OUT_FEAT+o)*W_W +: W_W];
  end

  // Aggregation adds a masked neighbour feature; MAC adds agg*w, both wrap mod 2^ACC_W.
  assign term_ext = adj_arr[n_q][m_q] ? ACC_W'(x_mem[m_q][f_q]) : '0;
  assign prod     = agg_mem[n_q][f_q] * w_arr[f_q][o_q];
  assign prod_ext = ACC_W'(prod);
  assign aggr_sum = acc_q + term_ext;
  assign mac_sum  = acc_q + prod_ext;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    f_d     = f_q;
    o_d     = o_q;
    acc_d   = acc_q;
    out_d   = out_q;
    done_c  = 1'b0;
    x_we    = 1'b0;
    agg_we  = 1'b0;
    case (state_q)
      S_LOAD: begin
        acc_d = '0;
        if (bus.in_valid) begin
          x_we = 1'b1;
          if (f_q == F_LAST) begin
            f_d = '0;
            if (n_q == N_LAST) begin
              n_d     = '0;
              state_d = S_AGGR;
            end else n_d = n_q + 1'b1;
          end else f_d = f_q + 1'b1;
        end
      end
      S_AGGR: begin
        if (m_q == N_LAST) begin
          agg_we = 1'b1;
          acc_d  = '0;
          m_d    = '0;
          if (f_q == F_LAST) begin
            f_d = '0;
            if (n_q == N_LAST) begin
              n_d     = '0;
              o_d     = '0;
              state_d = S_MAC;
            end else n_d = n_q + 1'b1;
          end else f_d = f_q + 1'b1;
        end else begin
          acc_d = aggr_sum;
          m_d   = m_q + 1'b1;
        end
      end
      S_MAC: begin
        if (f_q == F_LAST) begin
          f_d     = '0;
          acc_d   = '0;
          out_d   = fmt_out(mac_sum);
          state_d = S_OUT;
        end else begin
          acc_d = mac_sum;
          f_d   = f_q + 1'b1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_MAC;
          if (o_q == O_LAST) begin
            o_d = '0;
            if (n_q == N_LAST) begin
              n_d     = '0;
              done_c  = 1'b1;
              state_d = S_LOAD;
            end else n_d = n_q + 1'b1;
          end else o_d = o_q + 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      n_q     <= '0;
      m_q     <= '0;
      f_q     <= '0;
      o_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      f_q     <= f_d;
      o_q     <= o_d;
      out_q   <= out_d;
    end
  end

  // Datapath storage carries no reset; acc is cleared every LOAD cycle instead.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (x_we)   x_mem[n_q][f_q]   <= bus.in_data;
    if (agg_we) agg_mem[n_q][f_q] <= aggr_sum[AGG_W-1:0];
  end

  assign bus.in_ready  = (state_q == S_LOAD) && !rst;
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = out_q;
  assign bus.out_node  = n_q;
  assign bus.out_feat  = o_q;
  assign bus.busy      = (state_q != S_LOAD);
  assign bus.done      = done_c;
endmodule
